data_memory: RTL
================

# data_memory

Data-memory responder on the load/store memory bus. Accepts one read or write request at a time from the load or store unit and performs a byte, halfword or word access on an internal byte-addressed RAM. Holds `memory_busy` high for a fixed latency, then returns read data right-justified and zero-extended. Sign extension is the initiator's job. Sits between the execute-stage load/store units and the on-chip data RAM.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; byte range is `0 .. DEPTH_WORDS*4-1`.
- `LATENCY`, 2: busy cycles per access, ≥1.
- `clk` input 1: clock; all state changes on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `memory_address` input 32: byte address.
- `memory_width` input 4: access size in bytes; legal values 1, 2, 4.
- `memory_read_request` input 1: read request.
- `memory_write_request` input 1: write request.
- `memory_write_data` input 32: store data, right-justified; only the low `memory_width` bytes are used.
- `memory_data` output 32: read result, zero-extended; 0 after a write or a fault.
- `memory_busy` output 1: access in progress.
- `memory_fault` output 1: last access was rejected; valid while idle.

## Operation
- Reset:
  - `memory_data` = 0, `memory_busy` = 0, `memory_fault` = 0, state IDLE.
  - RAM contents are not cleared.
- States: IDLE, BUSY, plus SPLIT (only with the configuration macro enabled).
- Acceptance:
  - In IDLE, a posedge with exactly one request high captures address, width, direction and write data.
  - The block then goes to BUSY with counter = `LATENCY`-1.
- Both requests high in IDLE:
  - The request is accepted as a fault access.
  - No RAM change.
- Requests seen in BUSY or SPLIT are ignored, not queued. Initiators hold a request for at most one cycle.
- BUSY: the counter decrements each cycle. When it reaches 0, the access completes:
  - **Read:** `memory_data` = RAM bytes `[addr .. addr+width-1]`, little-endian, byte `addr` at bits [7:0], upper bits 0.
  - **Write:** the low `width` bytes of the captured data go to bytes `[addr .. addr+width-1]`. Other bytes of the word are unchanged. `memory_data` = 0.
  - The block returns to IDLE. `memory_fault` = 0.
- Fault conditions (checked at capture, reported at completion):
  - width not in {1, 2, 4};
  - both requests high;
  - `addr + width - 1 ≥ DEPTH_WORDS*4`;
  - misaligned (`addr % width ≠ 0`) when the macro is disabled.
- On a fault there is no RAM write, `memory_data` = 0 and `memory_fault` = 1. The fault takes the same `LATENCY` cycles as a normal access.
- `memory_data` and `memory_fault` hold their values until the next access completes.
- Reset asserted mid-access:
  - The block returns to IDLE immediately.
  - A pending write is dropped; no partial write occurs.

## Timing
- Request sampled at edge N → `memory_busy` = 1 from just after N.
- Completion at edge N+`LATENCY` → `memory_busy` = 0 and results valid after that edge.
- A load unit that samples `!memory_busy` at edge N+1 or later sees the correct data.
- Back-to-back: a new request can be sampled at the same edge where busy is first seen low.
- A read issued after a write completes returns the written data; there is no hazard.
- `memory_busy` is a registered state decode; no output has a combinational path from the inputs.

## Configuration
- `DATA_MEMORY_MISALIGNED_EN`
  - **Defined:**
    - Misaligned accesses are legal.
    - An access contained in one aligned word completes in `LATENCY` cycles.
    - An access crossing a word boundary goes BUSY → SPLIT: the first word is handled at the end of BUSY, and the second word one cycle later in SPLIT.
    - Busy therefore lasts `LATENCY`+1 cycles for a crossing access.
    - Out-of-range and illegal-width checks still apply.
  - **Undefined:** any misaligned access faults. The SPLIT state and second-word logic are not built.

## Test plan
- Reset, then write word 0xDEADBEEF at 0x10 with `LATENCY`=2, then read width 1 at 0x11 → busy high for exactly 2 cycles per access; read data 0x000000BE, fault 0.
- Write halfword 0x00001234 at 0x12 after the previous write, then read word 0x10 → 0x1234BEEF; bytes 0x10–0x11 unchanged.
- Read word at 0x02:
  - macro undefined → fault 1, data 0;
  - macro defined, with words 0x00 = 0x44332211 and 0x04 = 0x88776655 → 0x66554433; busy lasts 3 cycles.
- Width 3, both requests high, and a read at `DEPTH_WORDS*4` → each faults after `LATENCY` cycles; a following word read at 0x10 shows RAM unchanged.
- Second request pulsed while busy → ignored; busy length unchanged; only the first access's result appears.
- Assert `rst_n` low during a busy word write of 0xCAFEF00D to 0x20 holding 0 → busy 0, data 0 immediately; a later read of 0x20 returns 0.

Source files
------------

// File: rtl/data_memory.sv
// Load/store data-memory responder: one byte/halfword/word access at a time, fixed LATENCY busy window.
// Optional DATA_MEMORY_MISALIGNED_EN allows misaligned accesses; word-crossing ones take an extra SPLIT cycle.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] memory_address,
  input  logic [3:0]  memory_width,
  input  logic        memory_read_request,
  input  logic        memory_write_request,
  input  logic [31:0] memory_write_data,
  output logic [31:0] memory_data,
  output logic        memory_busy,
  output logic        memory_fault
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
`ifdef DATA_MEMORY_MISALIGNED_EN
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif

  // IDLE | waiting for a request;  BUSY | latency countdown, first word at terminal count;
  // SPLIT | second word of a word-crossing access (misaligned build only)
`ifdef DATA_MEMORY_MISALIGNED_EN
  typedef enum logic [1:0] {IDLE, BUSY, SPLIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t state_q, state_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       addr_off_q;
  logic [3:0]       bmask_q;
  logic             write_q;
  logic             fault_q;
  logic [31:0]      wdata_q;

  logic        req_any, req_both, width_ok, out_of_range, req_fault;
  logic [32:0] last_byte;

  assign req_any      = memory_read_request | memory_write_request;
  assign req_both     = memory_read_request & memory_write_request;
  assign width_ok     = (memory_width == 4'd1) || (memory_width == 4'd2) || (memory_width == 4'd4);
  assign last_byte    = {1'b0, memory_address} + {29'd0, memory_width} - 33'd1;
  assign out_of_range = last_byte >= BYTE_LIMIT;

`ifdef DATA_MEMORY_MISALIGNED_EN
  logic             req_cross, cross_q;
  logic [31:0]      rd_lo_q, rd_hi, rd_split;
  logic [IDX_W-1:0] idx_next;
  assign req_cross = ({3'b000, memory_address[1:0]} + {1'b0, memory_width}) > 5'd4;
  assign req_fault = req_both | ~width_ok | out_of_range;
  assign idx_next  = idx_q + IDX_W'(1);
  assign rd_hi     = mem[idx_next];
`else
  logic misaligned;
  assign misaligned = ((memory_width == 4'd2) && memory_address[0]) ||
                      ((memory_width == 4'd4) && (memory_address[1:0] != 2'b00));
  assign req_fault  = req_both | ~width_ok | out_of_range | misaligned;
`endif

  logic [31:0] rd_word, rd_mask, rd_aligned;
  assign rd_word    = mem[idx_q];
  assign rd_mask    = {{8{bmask_q[3]}}, {8{bmask_q[2]}}, {8{bmask_q[1]}}, {8{bmask_q[0]}}};
  assign rd_aligned = (rd_word >> {addr_off_q, 3'b000}) & rd_mask;
`ifdef DATA_MEMORY_MISALIGNED_EN
  assign rd_split   = 32'({rd_hi, rd_lo_q} >> {addr_off_q, 3'b000}) & rd_mask;
`endif

  // Store data and byte enables placed at their byte lanes; upper half belongs to the next word.
  logic [LANES*8-1:0] wdata_shift;
  logic [LANES-1:0]   be_shift;
  assign wdata_shift = (LANES*8)'(wdata_q) << {addr_off_q, 3'b000};
  assign be_shift    = LANES'(bmask_q) << addr_off_q;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             last_cycle;
  assign last_cycle = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = wdata_shift[31:0];
    wr_be   = be_shift[3:0];
    if (last_cycle && write_q && !fault_q) wr_en = 1'b1;
`ifdef DATA_MEMORY_MISALIGNED_EN
    if (state_q == SPLIT && write_q) begin
      wr_en   = 1'b1;
      wr_idx  = idx_next;
      wr_data = wdata_shift[63:32];
      wr_be   = be_shift[7:4];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_any) state_d = BUSY;
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
`ifdef DATA_MEMORY_MISALIGNED_EN
          if (cross_q && !fault_q) state_d = SPLIT;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memory_data  <= '0;
      memory_fault <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      addr_off_q   <= '0;
      bmask_q      <= '0;
      write_q      <= 1'b0;
      fault_q      <= 1'b0;
      wdata_q      <= '0;
`ifdef DATA_MEMORY_MISALIGNED_EN
      cross_q      <= 1'b0;
      rd_lo_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            cnt_q      <= CNT_LOAD;
            idx_q      <= memory_address[IDX_W+1:2];
            addr_off_q <= memory_address[1:0];
            bmask_q    <= (memory_width == 4'd4) ? 4'hF : (memory_width == 4'd2) ? 4'h3 : 4'h1;
            write_q    <= memory_write_request;
            wdata_q    <= memory_write_data;
            fault_q    <= req_fault;
`ifdef DATA_MEMORY_MISALIGNED_EN
            cross_q    <= req_cross;
`endif
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (fault_q) begin
            memory_data  <= '0;
            memory_fault <= 1'b1;
`ifdef DATA_MEMORY_MISALIGNED_EN
          end else if (cross_q) begin
            rd_lo_q <= rd_word;
`endif
          end else begin
            memory_data  <= write_q ? 32'd0 : rd_aligned;
            memory_fault <= 1'b0;
          end
        end
`ifdef DATA_MEMORY_MISALIGNED_EN
        SPLIT: begin
          memory_data  <= write_q ? 32'd0 : rd_split;
          memory_fault <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign memory_busy = (state_q != IDLE);

endmodule
